// File: rtl/mux_cell.sv
// mux_cell: 2:1 selector with zero-latency output, enabled registered copy
// and a saturating count of select-line changes.
module mux_cell #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] out_q,
  output logic [CNT_W-1:0] sel_chg_cnt
);
  logic sel_d;
  assign out = sel ? b : a;
  // sel_d resets to 0, so a high sel on the first edge after reset counts as a change
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_q       <= '0;
      sel_d       <= 1'b0;
      sel_chg_cnt <= '0;
    end else begin
      sel_d <= sel;
      if (en) out_q <= out;
      if (sel != sel_d && sel_chg_cnt != '1) sel_chg_cnt <= sel_chg_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_mux_cell.sv
// tb_mux_cell: directed vectors with literal expectations plus a per-cycle model check.
module tb_mux_cell;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0, s1 = 1'b0;
  logic       o0, o1, q0, q1;
  logic [7:0] c0, c1;
  logic [7:0] a8 = 8'h3c, b8 = 8'ha5, o8, q8, cnt8;
  logic       s8 = 1'b0, en8 = 1'b0;
  int vectors = 0, errs = 0;

  always #5 clk = ~clk;

  mux_cell #(.WIDTH(1)) u0 (.out(o0), .a(a1), .b(b1), .sel(s1), .clk(clk), .rst_n(rst_n),
                            .en(1'b0), .out_q(q0), .sel_chg_cnt(c0));
  mux_cell #(.WIDTH(1)) u1 (.out(o1), .a(o0), .b(o0), .sel(s1), .clk(clk), .rst_n(rst_n),
                            .en(1'b0), .out_q(q1), .sel_chg_cnt(c1));
  mux_cell #(.WIDTH(8), .CNT_W(8)) u8 (.out(o8), .a(a8), .b(b8), .sel(s8), .clk(clk), .rst_n(rst_n),
                            .en(en8), .out_q(q8), .sel_chg_cnt(cnt8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: out_q is the last selected value loaded with en; the counter is
  // the number of sampled sel changes since reset, clipped at 255.
  logic [7:0] m_q = '0;
  logic       m_last = 1'b0;
  int         m_changes = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_q = '0; m_last = 1'b0; m_changes = 0;
    end else begin
      if (s8 != m_last) m_changes++;
      m_last = s8;
      if (en8) m_q = s8 ? b8 : a8;
    end

  always @(negedge clk) begin
    chk("model_out", {24'd0, o8}, {24'd0, s8 ? b8 : a8});
    chk("model_out_q", {24'd0, q8}, {24'd0, m_q});
    chk("model_cnt", {24'd0, cnt8}, (m_changes > 255) ? 32'd255 : 32'(m_changes));
  end

  task automatic drive(input logic s, input logic e);
    @(negedge clk);
    #1 s8 = s; en8 = e;
  endtask

  logic [2:0] tt [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
  logic       tt_out [8] = '{0, 0, 0, 1, 1, 0, 1, 1};
  logic       xexp;

  initial begin
    // truth table and chained cell, purely combinational
    for (int i = 0; i < 8; i++) begin
      {a1, b1, s1} = tt[i];
      #1;
      chk($sformatf("tt_out_%0d", i), {31'd0, o0}, {31'd0, tt_out[i]});
      chk($sformatf("chain_out_%0d", i), {31'd0, o1}, {31'd0, tt_out[i]});
    end
    // X select: agreeing bits pass, differing bits follow ?: semantics
    a1 = 1'b1; b1 = 1'b1; s1 = 1'bx;
    #1 chk("xsel_agree", {31'd0, o0}, 32'd1);
    a1 = 1'b0; b1 = 1'b1; xexp = s1 ? b1 : a1;
    #1 chk("xsel_differ", {31'd0, o0}, {31'd0, xexp});
    s1 = 1'b0;
    // registered path
    @(negedge clk);
    chk("rst_out_q", {24'd0, q8}, 32'h00);
    chk("rst_cnt", {24'd0, cnt8}, 32'd0);
    #1 rst_n = 1'b1;
    drive(1'b0, 1'b1);
    @(posedge clk) #1 chk("load_a", {24'd0, q8}, 32'h3c);
    drive(1'b1, 1'b1);
    @(posedge clk) #1 chk("load_b", {24'd0, q8}, 32'ha5);
    chk("cnt_first", {24'd0, cnt8}, 32'd1);
    drive(1'b0, 1'b0);
    @(posedge clk) #1 chk("hold_q", {24'd0, q8}, 32'ha5);
    chk("hold_out", {24'd0, o8}, 32'h3c);
    for (int i = 0; i < 5; i++) drive(~s8, 1'b0);
    @(posedge clk) #1 chk("cnt_seven", {24'd0, cnt8}, 32'd7);
    chk("q_before_rst", {24'd0, q8}, 32'ha5);
    // asynchronous reset between edges
    @(negedge clk) #2 rst_n = 1'b0;
    #1 chk("async_q", {24'd0, q8}, 32'h00);
    chk("async_cnt", {24'd0, cnt8}, 32'd0);
    a8 = 8'h11; b8 = 8'h22; s8 = 1'b1;
    #1 chk("rst_out_b", {24'd0, o8}, 32'h22);
    s8 = 1'b0;
    #1 chk("rst_out_a", {24'd0, o8}, 32'h11);
    @(posedge clk) #1 chk("rst_hold_q", {24'd0, q8}, 32'h00);
    // saturating counter
    @(negedge clk) #1 rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(~s8, 1'b1);
      if (i == 9) @(posedge clk) #1 chk("cnt_ten", {24'd0, cnt8}, 32'd10);
    end
    @(posedge clk) #1 chk("cnt_sat", {24'd0, cnt8}, 32'd255);
    for (int i = 0; i < 5; i++) drive(s8, 1'b1);
    @(posedge clk) #1 chk("cnt_sat_hold", {24'd0, cnt8}, 32'd255);
    @(negedge clk);
    #1 $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
